// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, then payload MSB first, then idle gap bits.
// Feeds the 1010 sequence detector on the receive side of the serial link.
module sync_frame_tx #(
  parameter int unsigned            DATA_W   = 8,
  parameter int unsigned            SYNC_W   = 4,
  parameter logic [SYNC_W-1:0]      SYNC_PAT = 4'b1010,
  parameter int unsigned            GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned FRAME_W = SYNC_W + DATA_W;
  localparam int unsigned MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MAX_ALL = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [FRAME_W-1:0] shreg, shreg_d;
  logic               data_out_d, out_valid_d, frame_start_d, frame_done_d;
  logic               in_ready_d, busy_d;

  // State, counter, frame shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      data_out    <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      shreg       <= shreg_d;
      data_out    <= data_out_d;
      out_valid   <= out_valid_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
    end
  end

  // Sync and payload share one shift register; its MSB is always the next bit on the wire
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d = SYNC;
          cnt_d   = CNT_W'(SYNC_W - 1);
          shreg_d = {SYNC_PAT, in_data};
        end
      end
      SYNC: begin
        shreg_d = shreg << 1;
        if (cnt == '0) begin
          state_d = DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        shreg_d = shreg << 1;
        if (cnt == '0) begin
          if (GAP == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = GAP_ST;
            cnt_d   = CNT_W'(GAP - 1);
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAP_ST: begin
        if (cnt == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge
    out_valid_d   = (state_d == SYNC) || (state_d == DATA);
    data_out_d    = out_valid_d & shreg_d[FRAME_W-1];
    frame_start_d = (state == IDLE) && (state_d == SYNC);
    frame_done_d  = (state_d == DATA) && (cnt_d == '0);
    in_ready_d    = (state_d == IDLE);
    busy_d        = !in_ready_d;
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: default-gap and zero-gap instances share stimulus,
// each checked every cycle against a cycle-offset frame model plus directed frame checks.
module tb_sync_frame_tx;

  localparam int FW = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic in_ready0, data_out0, out_valid0, frame_start0, frame_done0, busy0;
  logic in_ready1, data_out1, out_valid1, frame_start1, frame_done1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1010), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .data_out(data_out0), .out_valid(out_valid0), .frame_start(frame_start0),
    .frame_done(frame_done0), .busy(busy0));

  sync_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1010), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .data_out(data_out1), .out_valid(out_valid1), .frame_start(frame_start1),
    .frame_done(frame_done1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {in_ready, busy, out_valid, data_out, frame_start, frame_done} in cycle c,
  // for a frame whose handshake edge closed cycle hs (hs < 0: no frame since reset)
  function automatic logic [5:0] exp_out(input int gap, input int hs, input int c,
                                         input logic [11:0] fr);
    int   k;
    logic v, rdy, b;
    k   = (hs < 0) ? 0 : c - hs;
    v   = (hs >= 0) && (k >= 1) && (k <= FW);
    rdy = (hs < 0) || (k > FW + gap);
    b   = v ? fr[FW-k] : 1'b0;
    return {rdy, ~rdy, v, b, v && (k == 1), v && (k == FW)};
  endfunction

  int          cyc = 0;
  int          hs[2] = '{-1, -1};
  logic [11:0] frm[2];
  int          n_hs[2] = '{0, 0};
  int          gaps[2] = '{2, 0};

  int          st0[$], st1[$], hits[$], done0[$];
  logic [11:0] frames0[$];
  logic [11:0] cap0 = '0;
  logic [3:0]  hist = '0;
  int          nvalid = 0, ndone = 0;
  logic        prev_done1 = 1'b0;

  // Reference model and observers, evaluated once per cycle
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [5:0] e;
        e = exp_out(gaps[d], hs[d], cyc, frm[d]);
        if (rst) hs[d] = -1;
        else if (in_valid && e[5]) begin
          hs[d]  = cyc;
          frm[d] = {4'b1010, in_data};
          n_hs[d]++;
        end
      end
      cyc++;
      #1;
      chk("dut0_outputs", 32'({in_ready0, busy0, out_valid0, data_out0, frame_start0, frame_done0}),
          32'(exp_out(gaps[0], hs[0], cyc, frm[0])));
      chk("dut1_outputs", 32'({in_ready1, busy1, out_valid1, data_out1, frame_start1, frame_done1}),
          32'(exp_out(gaps[1], hs[1], cyc, frm[1])));
      if (frame_start0) st0.push_back(cyc);
      if (out_valid0) begin
        cap0 = {cap0[10:0], data_out0};
        nvalid++;
      end
      if (frame_done0) begin
        frames0.push_back(cap0);
        done0.push_back(cyc);
        ndone++;
      end
      hist = {hist[2:0], data_out0};
      if (hist == 4'b1010) hits.push_back(cyc);
      if (frame_start1) st1.push_back(cyc);
      if (prev_done1) chk("gap0_ready_after_done", 32'(in_ready1), 32'd1);
      prev_done1 = frame_done1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  initial begin
    int base, lim, d0;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;

    // Reset held with in_valid high: no handshake, outputs quiet
    repeat (3) @(negedge clk);
    chk("rst_no_handshake", 32'(n_hs[0] + n_hs[1]), 32'd0);
    chk("rst_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_ready", 32'(in_ready0), 32'd1);

    // Single frame 8'hC5
    frames0.delete(); st0.delete(); done0.delete();
    send(8'hC5);
    idle(16);
    chk("c5_frames", 32'(frames0.size()), 32'd1);
    if (frames0.size() >= 1) chk("c5_bits", 32'(frames0[0]), 32'hAC5);
    if (st0.size() >= 1 && done0.size() >= 1) chk("c5_start_to_done", 32'(done0[0] - st0[0]), 32'd11);

    // Back-to-back A5 then 3C, data scrambled while busy
    frames0.delete(); st0.delete();
    base     = n_hs[0];
    lim      = 0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    while (n_hs[0] < base + 2 && lim < 80) begin
      @(negedge clk);
      lim++;
      if (exp_out(gaps[0], hs[0], cyc, frm[0])[5]) in_data = (n_hs[0] == base) ? 8'hA5 : 8'h3C;
      else in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    if (lim >= 80) chk("b2b_timeout", 32'd1, 32'd0);
    idle(16);
    chk("b2b_frames", 32'(frames0.size()), 32'd2);
    if (frames0.size() >= 2) begin
      chk("b2b_first", 32'(frames0[0]), 32'hAA5);
      chk("b2b_second", 32'(frames0[1]), 32'hA3C);
    end
    if (st0.size() >= 2) chk("b2b_period", 32'(st0[1] - st0[0]), 32'd15);

    // Reset after 6 valid bits aborts the frame
    frames0.delete();
    base = nvalid;
    lim  = 0;
    send(8'h96);
    while (nvalid < base + 6 && lim < 40) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 40) chk("abort_timeout", 32'd1, 32'd0);
    d0  = ndone;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid0), 32'd0);
    chk("abort_no_done", 32'(ndone), 32'(d0));
    idle(2);
    send(8'hFF);
    idle(16);
    chk("abort_frames", 32'(frames0.size()), 32'd1);
    if (frames0.size() >= 1) chk("ff_bits", 32'(frames0[0]), 32'hAFF);

    // Loopback through a 1010 detector with an all-zero payload
    hits.delete(); st0.delete();
    send(8'h00);
    idle(16);
    chk("det_hits", 32'(hits.size()), 32'd1);
    if (hits.size() >= 1 && st0.size() >= 1) chk("det_on_4th_sync", 32'(hits[0] - st0[0]), 32'd3);

    // Zero gap instance: back-to-back period 13
    st1.delete();
    base     = n_hs[1];
    lim      = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    while (n_hs[1] < base + 2 && lim < 80) begin
      @(negedge clk);
      lim++;
    end
    in_valid = 1'b0;
    if (lim >= 80) chk("gap0_timeout", 32'd1, 32'd0);
    idle(16);
    chk("gap0_starts", 32'(st1.size() >= 2), 32'd1);
    if (st1.size() >= 2) chk("gap0_period", 32'(st1[1] - st1[0]), 32'd13);

    // Random traffic with occasional resets
    repeat (400) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
